// File: rtl/seq_rec_pkg.sv
// seq_rec_pkg: shared helpers for the multi-channel sequence recognizer.
//   clog2_min1  - ceiling log2 clamped to at least 1 (counter width helper)
//   min_ones_ok - legality check for the MIN_ONES parameter
package seq_rec_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic bit min_ones_ok(input int m);
    return m >= 1;
  endfunction

endpackage

// File: rtl/seq_rec_ch.sv
// seq_rec_ch: one recognizer channel.
//   clk, rst (async active-low), x_valid/x (qualified sample), clr (sync restart)
//   ones_cnt : saturating count of accepted 1s
//   zero_par : parity of accepted 0s (1 = odd)
//   f        : match flag, decoded from registered state only
//   f_rise   : one-cycle pulse on each 0->1 transition of f
module seq_rec_ch
  import seq_rec_pkg::*;
#(
  parameter int MIN_ONES = 2,
  parameter bit ZERO_ODD = 1'b1,
  localparam int unsigned ONES_W = clog2_min1(MIN_ONES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x_valid,
  input  logic              x,
  input  logic              clr,
  output logic [ONES_W-1:0] ones_cnt,
  output logic              zero_par,
  output logic              f,
  output logic              f_rise
);

  if (!min_ones_ok(MIN_ONES)) begin : g_bad_min_ones
    $error("seq_rec_ch: MIN_ONES must be >= 1");
  end

  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(MIN_ONES);

  logic f_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_cnt <= '0;
      zero_par <= 1'b0;
      f_d      <= 1'b0;
    end else if (clr) begin
      // restart drops the sample presented on the same edge
      ones_cnt <= '0;
      zero_par <= 1'b0;
      f_d      <= 1'b0;
    end else begin
      f_d <= f;
      if (x_valid) begin
        if (x) begin
          if (ones_cnt != ONES_MAX) ones_cnt <= ones_cnt + ONES_W'(1);
        end else begin
          zero_par <= ~zero_par;
        end
      end
    end
  end

  always_comb begin
    f      = (ones_cnt == ONES_MAX) && (zero_par == ZERO_ODD);
    f_rise = f & ~f_d;
  end

endmodule

// File: rtl/seq_rec_multi.sv
// seq_rec_multi: N_CH independent serial sequence recognizers.
//   clk, rst (async active-low, clears all channels)
//   x_valid, x, clr : per-channel sample qualifier, data bit, sync restart
//   F, F_rise       : per-channel match flag and its rise pulse
//   ones_cnt        : channel i at bits [i*ONES_W +: ONES_W]
//   zero_par        : per-channel parity of accepted zeros
module seq_rec_multi
  import seq_rec_pkg::*;
#(
  parameter int N_CH     = 1,
  parameter int MIN_ONES = 2,
  parameter bit ZERO_ODD = 1'b1,
  localparam int unsigned ONES_W = clog2_min1(MIN_ONES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          x_valid,
  input  logic [N_CH-1:0]          x,
  input  logic [N_CH-1:0]          clr,
  output logic [N_CH-1:0]          F,
  output logic [N_CH-1:0]          F_rise,
  output logic [N_CH*ONES_W-1:0]   ones_cnt,
  output logic [N_CH-1:0]          zero_par
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    seq_rec_ch #(
      .MIN_ONES (MIN_ONES),
      .ZERO_ODD (ZERO_ODD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .x_valid  (x_valid[i]),
      .x        (x[i]),
      .clr      (clr[i]),
      .ones_cnt (ones_cnt[i*ONES_W +: ONES_W]),
      .zero_par (zero_par[i]),
      .f        (F[i]),
      .f_rise   (F_rise[i])
    );
  end

endmodule

// File: tb/tb_seq_rec_multi.sv
module tb_seq_rec_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (1 channel, MIN_ONES=2, ZERO_ODD=1)
  logic       rst_a = 1'b0;
  logic [0:0] va = '0, xa = '0, ca = '0;
  logic [0:0] fa, ra, pa;
  logic [1:0] cnta;

  seq_rec_multi dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .x_valid  (va),
    .x        (xa),
    .clr      (ca),
    .F        (fa),
    .F_rise   (ra),
    .ones_cnt (cnta),
    .zero_par (pa)
  );

  // DUT B: 4 channels, MIN_ONES=3, ZERO_ODD=0
  logic       rst_b = 1'b0;
  logic [3:0] vb = '0, xb = '0, cb = '0;
  logic [3:0] fb, rb, pb;
  logic [7:0] cntb;

  seq_rec_multi #(
    .N_CH     (4),
    .MIN_ONES (3),
    .ZERO_ODD (1'b0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .x_valid  (vb),
    .x        (xb),
    .clr      (cb),
    .F        (fb),
    .F_rise   (rb),
    .ones_cnt (cntb),
    .zero_par (pb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- table for DUT A ----------------
  typedef struct {
    logic       v, x, c;
    logic [1:0] cnt;
    logic       par, f, rise;
  } vec_t;
  vec_t tbl[$];

  // ---------------- reference model for DUT B ----------------
  // Counts every accepted 1 and 0 since the last restart; the
  // saturated count and parity are derived arithmetically.
  int unsigned os[4];
  int unsigned zs[4];
  bit          prev_f[4];

  task automatic step_b(input logic [3:0] v, input logic [3:0] x, input logic [3:0] c,
                        input string tag);
    logic [7:0] e_cnt;
    logic [3:0] e_par, e_f, e_rise;
    int unsigned sat;
    vb = v; xb = x; cb = c;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      if (c[ch]) begin
        os[ch] = 0;
        zs[ch] = 0;
      end else if (v[ch] && x[ch]) begin
        os[ch]++;
      end else if (v[ch]) begin
        zs[ch]++;
      end
      sat = (os[ch] >= 3) ? 3 : os[ch];
      e_cnt[ch*2 +: 2] = 2'(sat);
      e_par[ch]  = zs[ch][0];
      e_f[ch]    = (os[ch] >= 3) && (zs[ch] % 2 == 0);
      e_rise[ch] = e_f[ch] && !prev_f[ch];
      prev_f[ch] = e_f[ch];
    end
    chk({tag, " cnt"},  32'(cntb), 32'(e_cnt));
    chk({tag, " par"},  32'(pb),   32'(e_par));
    chk({tag, " F"},    32'(fb),   32'(e_f));
    chk({tag, " rise"}, 32'(rb),   32'(e_rise));
  endtask

  task automatic check_a(input string tag, input logic [1:0] cnt, input logic par,
                         input logic f, input logic rise);
    chk({tag, " cnt"},  32'(cnta), 32'(cnt));
    chk({tag, " par"},  32'(pa),   32'(par));
    chk({tag, " F"},    32'(fa),   32'(f));
    chk({tag, " rise"}, 32'(ra),   32'(rise));
  endtask

  initial begin
    for (int ch = 0; ch < 4; ch++) begin
      os[ch] = 0; zs[ch] = 0; prev_f[ch] = 1'b0;
    end

    //            v     x     c     cnt  par   F     rise
    // stream 1,0,1 then idle
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0});
    // two more zeros: drop then re-rise
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0});
    // restart, then unqualified toggling, then two accepted 1s
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0});
    // saturation: five 1s from restart, then a zero
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0});
    // clr wins over a qualified zero, and over a qualified one
    tbl.push_back('{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0});

    // reset held across edges with activity on the inputs
    va = 1'b1; xa = 1'b1; ca = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset B cnt", 32'(cntb), 32'h0);
    chk("reset B F",   32'(fb),   32'h0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    va = 1'b0; xa = 1'b0;

    foreach (tbl[i]) begin
      va = tbl[i].v; xa = tbl[i].x; ca = tbl[i].c;
      @(posedge clk);
      #1;
      check_a($sformatf("row%0d", i), tbl[i].cnt, tbl[i].par, tbl[i].f, tbl[i].rise);
    end

    // mid-cycle asynchronous reset during a new sequence
    va = 1'b1; ca = 1'b0;
    xa = 1'b1; @(posedge clk); #1;
    xa = 1'b0; @(posedge clk); #1;
    xa = 1'b1; @(posedge clk); #1;
    check_a("pre-rst", 2'd2, 1'b1, 1'b1, 1'b1);
    xa = 1'b1;
    #3;
    rst_a = 1'b0;
    #1;
    check_a("async rst", 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check_a("rst held", 2'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check_a("post-rst", 2'd1, 1'b0, 1'b0, 1'b0);
    va = 1'b0;

    // DUT B: channel 2 sees 1,1,0,0,1, the rest idle
    step_b(4'b0100, 4'b0100, 4'b0000, "ch2 s1");
    step_b(4'b0100, 4'b0100, 4'b0000, "ch2 s2");
    step_b(4'b0100, 4'b0000, 4'b0000, "ch2 s3");
    step_b(4'b0100, 4'b0000, 4'b0000, "ch2 s4");
    step_b(4'b0100, 4'b0100, 4'b0000, "ch2 s5");
    chk("ch2 final F",    32'(fb),   32'h4);
    chk("ch2 final rise", 32'(rb),   32'h4);
    chk("ch2 final cnt",  32'(cntb), 32'h30);
    chk("ch2 final par",  32'(pb),   32'h0);

    // randomized traffic on all four channels
    for (int n = 0; n < 300; n++) begin
      logic [3:0] rv, rx, rc;
      rv = 4'($urandom);
      rx = 4'($urandom);
      for (int ch = 0; ch < 4; ch++) rc[ch] = ($urandom_range(0, 15) == 0);
      step_b(rv, rx, rc, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
